pll_ce_gen: RTL
===============

// Module: pll_ce_gen
// PURPOSE
//  Parametrised successor to the fixed-ratio PLL wrapper: from one reference clock, derives NUM_CH
//  clock-enable streams at runtime-programmable fractional rates (phase accumulators). Adds a lock
//  model, per-channel reconfiguration handshake and phase realignment. Core logic stays on one clock
//  and uses the enables instead of extra PLL outputs. Sits beside the PLL in the sys clocking layer.
// PARAMETERS
//  NUM_CH      2                     number of enable channels (1..8)
//  ACC_W       16                    accumulator/increment width
//  SETTLE_CYC  256                   cycles from reset release / reconfig to locked (>=1)
//  DEF_INC     {16'd26214,16'd52429} packed reset increments, ch0 in LSBs (50 MHz -> 40 / 20 MHz)
// PORTS
//  refclk    in   1               single clock, all logic rising-edge
//  rst_n     in   1               asynchronous active-low reset
//  cfg_req   in   1               reconfig request, held until cfg_ack
//  cfg_ch    in   CH_W            target channel, CH_W = max(1,$clog2(NUM_CH))
//  cfg_inc   in   ACC_W           new increment for cfg_ch
//  cfg_ack   out  1               one-cycle acknowledge
//  ce        out  NUM_CH          registered clock enables, one-cycle pulses
//  locked    out  1               high when enables are valid
// BEHAVIOUR
//  - Reset (async assert, sync release): state=SETTLE, cnt=0, acc[i]=0, inc[i]=DEF_INC[i];
//    ce=0, locked=0, cfg_ack=0 immediately on rst_n low.
//  - Per channel in LOCKED: {carry,acc[i]} <= acc[i]+inc[i]; ce[i] <= carry (1-cycle latency).
//    Mean rate = inc[i]/2^ACC_W * f_refclk; inc=0 -> ce never; no rounding beyond ACC_W bits.
//  - FSM SETTLE: acc held 0, ce=0, locked=0; cnt++ each cycle; at cnt==SETTLE_CYC-1 -> LOCKED.
//  - FSM LOCKED: locked=1, accumulators run.
//  - cfg_req sampled high at edge T in SETTLE or LOCKED (and cfg_ack low): at T+1 cfg_ack=1 for one
//    cycle, inc[cfg_ch]<=cfg_inc (write dropped if cfg_ch>=NUM_CH, ack still given), ALL acc cleared
//    (phase realignment), ce=0, locked=0, cnt=0, state=SETTLE. locked rises at T+1+SETTLE_CYC.
//  - cfg_req high during the cfg_ack cycle is ignored; if still high the cycle after, it is a new
//    transaction. Requester drops cfg_req on seeing cfg_ack.
//  - cfg_req during SETTLE restarts the count (settle extends; no partial lock).
//  - After lock, first ce[i] is at the first cycle acc+inc carries, all channels from acc=0 on the
//    same cycle, so channel phases are deterministic after every lock.
//  - Reset mid-settle or mid-reconfig: pending write lost, increments return to DEF_INC.
// STRUCTURE
//  - Package pll_ce_pkg: state enum {ST_SETTLE, ST_LOCKED}, CH_W helper function, max channel const.
//  - Sub-module pll_ce_accum (one channel: inc register, accumulator, carry->ce register, clear and
//    run inputs, load strobe), generated NUM_CH times; top holds FSM, settle counter, handshake.
// TESTING
//  - Defaults, release rst_n at 0: locked rises cycle 256; over next 5000 cycles ce[0]=4000+-1,
//    ce[1]=2000+-1 pulses; ce never high before locked.
//  - Reconfig ch1 inc=16'h8000 while locked: cfg_ack 1 cycle, locked low 256 cycles, then ce[1] exactly
//    every 2nd cycle, ce[0] restarts from acc=0 (first pulse cycle 2 after lock).
//  - cfg_inc=0 on ch0 -> ce[0] constant 0 after lock; ch1 unaffected in rate.
//  - NUM_CH=3, cfg_ch=3 -> cfg_ack given, all increments unchanged, lock still re-sequences.
//  - cfg_req at settle cnt=200 -> ack, count restarts, locked at ack+256; cfg_req held 2 cycles
//    after ack -> exactly two acks.
//  - rst_n low for 1 cycle while locked -> ce, locked, cfg_ack drop with no clock edge; DEF_INC restored.

Source files
------------

// File: rtl/pll_ce_pkg.sv
// rtl/pll_ce_pkg.sv - shared types and helpers for the clock-enable generator
package pll_ce_pkg;

  typedef enum logic {
    ST_SETTLE = 1'b0,
    ST_LOCKED = 1'b1
  } pll_state_e;

  localparam int MAX_CH = 8;

  function automatic int ch_width(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/pll_ce_accum.sv
// rtl/pll_ce_accum.sv - one phase-accumulator channel producing a registered clock enable
module pll_ce_accum #(
  parameter int               ACC_W   = 16,
  parameter logic [ACC_W-1:0] DEF_INC = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             run,
  input  logic             load,
  input  logic [ACC_W-1:0] load_inc,
  output logic             ce
);

  logic [ACC_W-1:0] inc_q;
  logic [ACC_W-1:0] acc_q;
  logic [ACC_W:0]   sum;

  assign sum = {1'b0, acc_q} + {1'b0, inc_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inc_q <= DEF_INC;
      acc_q <= '0;
      ce    <= 1'b0;
    end else begin
      if (load) begin
        inc_q <= load_inc;
      end
      // clear wins over run so every channel restarts from the same phase
      if (clear) begin
        acc_q <= '0;
        ce    <= 1'b0;
      end else if (run) begin
        acc_q <= sum[ACC_W-1:0];
        ce    <= sum[ACC_W];
      end else begin
        ce    <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/pll_ce_gen.sv
// rtl/pll_ce_gen.sv - programmable fractional clock-enable generator with lock model
module pll_ce_gen
  import pll_ce_pkg::*;
#(
  parameter int                      NUM_CH     = 2,
  parameter int                      ACC_W      = 16,
  parameter int                      SETTLE_CYC = 256,
  parameter logic [NUM_CH*ACC_W-1:0] DEF_INC    = {16'd26214, 16'd52429},
  localparam int                     CH_W       = ch_width(NUM_CH)
) (
  input  logic              refclk,
  input  logic              rst_n,
  input  logic              cfg_req,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [ACC_W-1:0]  cfg_inc,
  output logic              cfg_ack,
  output logic [NUM_CH-1:0] ce,
  output logic              locked
);

  localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  pll_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             cnt_done;
  logic             cfg_take;
  logic             run;

  assign cnt_done = (cnt_q == CNT_W'(SETTLE_CYC - 1));
  // a request seen during the ack cycle is the previous transaction still held
  assign cfg_take = cfg_req && !cfg_ack;

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_SETTLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (cfg_take) begin
      state_d = ST_SETTLE;
    end else if (state_q == ST_SETTLE && cnt_done) begin
      state_d = ST_LOCKED;
    end
  end

  always_comb begin
    locked = 1'b0;
    run    = 1'b0;
    if (state_q == ST_LOCKED) begin
      locked = 1'b1;
      run    = 1'b1;
    end
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      cfg_ack <= 1'b0;
    end else begin
      cfg_ack <= cfg_take;
      if (cfg_take || state_q == ST_LOCKED) begin
        cnt_q <= '0;
      end else if (!cnt_done) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    pll_ce_accum #(
      .ACC_W   (ACC_W),
      .DEF_INC (DEF_INC[i*ACC_W +: ACC_W])
    ) u_accum (
      .clk      (refclk),
      .rst_n    (rst_n),
      .clear    (cfg_take),
      .run      (run),
      .load     (cfg_take && (cfg_ch == CH_W'(i))),
      .load_inc (cfg_inc),
      .ce       (ce[i])
    );
  end

endmodule
